hit_tracker: RTL and testbench
==============================

HIT_TRACKER -- requirements
Module: hit_tracker

Interface
REQ-001 Parameter NUM_METEORS, default 4: number of meteor boxes checked.
REQ-002 Parameter LIVES_INIT, default 3: lives loaded at game start.
REQ-003 Parameter INVULN_FRAMES, default 60: frames of invulnerability after a hit.
REQ-004 frame_clk  in  1  frame-rate clock, rising-edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  level request to begin/restart a game; sampled on frame_clk.
REQ-007 ShipX, ShipY, ShipS  in  10 each  ship centre and half-size (player position stage outputs).
REQ-008 MetX, MetY, MetS  in  NUM_METEORS*10 each  packed meteor centres and half-sizes, meteor i at bits [10i+9:10i].
REQ-009 state  out  2  current game state, encoded per shared package.
REQ-010 lives  out  2  remaining lives.
REQ-011 hit  out  1  one-frame pulse on each accepted collision.
REQ-012 invuln  out  1  high while in INVULN.
REQ-013 game_over  out  1  high while in OVER.
REQ-014 score  out  16  frames survived in the current game.

Function
REQ-015 Overlap with meteor i SHALL be true iff MetS[i]!=0, |ShipX-MetX[i]| < ShipS+MetS[i] and |ShipY-MetY[i]| < ShipS+MetS[i], computed combinationally in 11-bit unsigned arithmetic with no truncation.
REQ-016 Any-collision SHALL be the OR of all NUM_METEORS overlaps; multiple simultaneous overlaps count as one hit.
REQ-017 FSM states: IDLE, PLAY, INVULN, OVER.
REQ-018 IDLE: start=1 -> PLAY, lives<=LIVES_INIT, score<=0; otherwise stay.
REQ-019 PLAY: collision and lives>1 -> INVULN, lives decremented, invuln counter<=INVULN_FRAMES-1, hit=1 for that next frame.
REQ-020 PLAY: collision and lives==1 -> OVER, lives<=0, hit=1 for that next frame.
REQ-021 PLAY: start is ignored; collision has priority over start.
REQ-022 INVULN: collisions ignored; counter decrements each frame; at counter==0 -> PLAY.
REQ-023 A collision still present on the first PLAY frame after INVULN SHALL be accepted normally.
REQ-024 OVER: lives, score hold; start=1 -> PLAY with lives<=LIVES_INIT, score<=0.
REQ-025 score SHALL increment by 1 on every frame spent in PLAY or INVULN and saturate at 16'hFFFF.
REQ-026 hit SHALL be registered: high exactly one frame_clk cycle, the cycle after the edge that sampled the collision.
REQ-027 invuln and game_over SHALL be decoded from the registered state, with no added latency.

Reset
REQ-028 Reset SHALL asynchronously force state=IDLE, lives=0, hit=0, score=0, invuln counter=0, invuln=0, game_over=0.
REQ-029 Reset asserted mid-game SHALL abandon the game; the first start after release begins a fresh game.

Configuration
REQ-030 Macro HIT_TRACKER_SCORE_EN defined: score counter per REQ-025.
REQ-031 Macro HIT_TRACKER_SCORE_EN undefined: no score register is instantiated; score tied to 16'h0000; all other behaviour unchanged.

Structure
REQ-032 Package game_pkg SHALL hold the state enum (IDLE=0, PLAY=1, INVULN=2, OVER=3), coordinate width 10, and default values for NUM_METEORS, LIVES_INIT and INVULN_FRAMES.
REQ-033 Sub-module box_overlap SHALL implement REQ-015 for one ship/meteor pair and be instantiated NUM_METEORS times in a generate loop.

Verification
REQ-034 Reset, start=1 one frame -> state=PLAY, lives=3, score counts 1,2,3 on successive frames.
REQ-035 Ship (100,100,S=8), meteor0 (110,100,S=4): overlap (10<12) -> hit pulse for one frame, lives=2, invuln=1 for 60 frames, then PLAY.
REQ-036 Meteor0 at (112,100,S=4): no overlap (12 not <12) -> no hit; meteor with MetS=0 on ship centre -> no hit.
REQ-037 Three overlapping meteors in one frame -> single hit, lives drop by exactly 1; third accepted hit -> OVER, lives=0, game_over=1, score frozen.
REQ-038 OVER, start=1 -> PLAY, lives=3, score=0; Reset asserted during INVULN -> IDLE, all outputs at reset values immediately.
REQ-039 Build without HIT_TRACKER_SCORE_EN -> REQ-034 sequence with score constantly 0.

Source files
------------

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the meteor game pipeline.
//   - game_state_e  : game state encoding (IDLE=0, PLAY=1, INVULN=2, OVER=3)
//   - S_*           : the same encodings as plain logic [1:0] constants, used by
//                     FSM code that stores state in a plain vector
//   - COORD_W       : width of every screen coordinate / half-size (10 bits)
//   - *_DEF         : default values for the hit_tracker parameters
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int COORD_W = 10;

  localparam int NUM_METEORS_DEF   = 4;
  localparam int LIVES_INIT_DEF    = 3;
  localparam int INVULN_FRAMES_DEF = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } game_state_e;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_PLAY   = PLAY;
  localparam logic [1:0] S_INVULN = INVULN;
  localparam logic [1:0] S_OVER   = OVER;

endpackage

// File: rtl/box_overlap.sv
// -----------------------------------------------------------------------------
// box_overlap
// Combinational overlap test between the ship box and one meteor box. Both
// boxes are squares given by centre and half-size. They overlap when the
// centre distance on each axis is strictly less than the sum of half-sizes.
// A meteor with half-size 0 is an empty slot and never overlaps.
//
// Ports
//   ship_x_i, ship_y_i, ship_s_i : ship centre and half-size
//   met_x_i,  met_y_i,  met_s_i  : meteor centre and half-size
//   overlap_o                    : 1 when the boxes overlap
// -----------------------------------------------------------------------------
module box_overlap
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] ship_x_i,
  input  logic [COORD_W-1:0] ship_y_i,
  input  logic [COORD_W-1:0] ship_s_i,
  input  logic [COORD_W-1:0] met_x_i,
  input  logic [COORD_W-1:0] met_y_i,
  input  logic [COORD_W-1:0] met_s_i,
  output logic               overlap_o
);

  // One extra bit so the half-size sum (up to 2046) never wraps.
  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;
  logic [COORD_W:0] reach;

  always_comb begin
    dx = (ship_x_i >= met_x_i) ? {1'b0, ship_x_i - met_x_i}
                               : {1'b0, met_x_i - ship_x_i};
    dy = (ship_y_i >= met_y_i) ? {1'b0, ship_y_i - met_y_i}
                               : {1'b0, met_y_i - ship_y_i};
    reach     = {1'b0, ship_s_i} + {1'b0, met_s_i};
    overlap_o = (met_s_i != '0) && (dx < reach) && (dy < reach);
  end

endmodule

// File: rtl/hit_tracker.sv
// -----------------------------------------------------------------------------
// hit_tracker
// Tracks ship/meteor collisions, lives, a post-hit invulnerability window and
// the survival score for one game. Runs once per frame on frame_clk.
//
// Ports
//   frame_clk        : frame-rate clock, rising edge
//   Reset            : asynchronous, active-high reset
//   start            : level request to begin / restart a game (a plain level
//                      sampled each frame; there is no handshake on this block)
//   ShipX/ShipY/ShipS: ship centre and half-size
//   MetX/MetY/MetS   : packed meteor centres / half-sizes, meteor i at
//                      bits [10i+9:10i]
//   state            : registered game state (game_pkg encoding), also the FSM
//                      debug view
//   lives            : remaining lives
//   hit              : one-frame pulse per accepted collision
//   invuln           : high while in INVULN
//   game_over        : high while in OVER
//   score            : frames survived in the current game
//
// Build option
//   HIT_TRACKER_SCORE_EN : when defined, score counts frames spent in PLAY or
//                          INVULN (saturating). When undefined there is no
//                          score register and score reads 16'h0000.
// -----------------------------------------------------------------------------
module hit_tracker
  import game_pkg::*;
#(
  parameter int NUM_METEORS   = NUM_METEORS_DEF,
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic                           start,
  input  logic [COORD_W-1:0]             ShipX,
  input  logic [COORD_W-1:0]             ShipY,
  input  logic [COORD_W-1:0]             ShipS,
  input  logic [NUM_METEORS*COORD_W-1:0] MetX,
  input  logic [NUM_METEORS*COORD_W-1:0] MetY,
  input  logic [NUM_METEORS*COORD_W-1:0] MetS,
  output logic [1:0]                     state,
  output logic [1:0]                     lives,
  output logic                           hit,
  output logic                           invuln,
  output logic                           game_over,
  output logic [15:0]                    score
);

  localparam int               CNT_W      = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);

  // ---------------------------------------------------------------------------
  // Collision detect: one box test per meteor, simultaneous overlaps merge
  // into a single collision.
  // ---------------------------------------------------------------------------
  logic [NUM_METEORS-1:0] overlap;
  logic                   collision;

  for (genvar i = 0; i < NUM_METEORS; i++) begin : g_box
    box_overlap u_box (
      .ship_x_i  (ShipX),
      .ship_y_i  (ShipY),
      .ship_s_i  (ShipS),
      .met_x_i   (MetX[i*COORD_W +: COORD_W]),
      .met_y_i   (MetY[i*COORD_W +: COORD_W]),
      .met_s_i   (MetS[i*COORD_W +: COORD_W]),
      .overlap_o (overlap[i])
    );
  end

  assign collision = |overlap;

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             hit_q,   hit_d;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          lives_d = LIVES_LOAD;
        end
      end
      S_PLAY: begin
        // start is deliberately not looked at here; a collision always wins.
        if (collision) begin
          hit_d = 1'b1;
          if (lives_q > 2'd1) begin
            state_d = S_INVULN;
            lives_d = lives_q - 2'd1;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = S_OVER;
            lives_d = 2'd0;
          end
        end
      end
      S_INVULN: begin
        // Counter was loaded with INVULN_FRAMES-1 so the window lasts exactly
        // INVULN_FRAMES frames including the one where it reaches zero.
        if (cnt_q == '0) begin
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      lives_q <= 2'd0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Score: counts every frame spent in PLAY or INVULN (including the frame
  // that ends in a fatal hit), cleared when a new game starts, held in OVER.
  // ---------------------------------------------------------------------------
`ifdef HIT_TRACKER_SCORE_EN
  logic [15:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (((state_q == S_IDLE) || (state_q == S_OVER)) && start) begin
      score_d = 16'h0000;
    end else if (((state_q == S_PLAY) || (state_q == S_INVULN)) &&
                 (score_q != 16'hFFFF)) begin
      score_d = score_q + 16'h0001;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      score_q <= 16'h0000;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all straight from registers or decoded from the registered state.
  // ---------------------------------------------------------------------------
  assign state     = state_q;
  assign lives     = lives_q;
  assign hit       = hit_q;
  assign invuln    = (state_q == S_INVULN);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_hit_tracker.sv
// -----------------------------------------------------------------------------
// tb_hit_tracker
// Self-checking bench for hit_tracker: directed game scenarios with literal
// expectations, then randomized frames checked every cycle against a
// frame-level game model. Honors HIT_TRACKER_SCORE_EN for score expectations.
// -----------------------------------------------------------------------------
module tb_hit_tracker;

  localparam int NM            = 4;
  localparam int LIVES_INIT    = 3;
  localparam int INVULN_FRAMES = 60;
  localparam int W             = 23;

`ifdef HIT_TRACKER_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic           frame_clk = 1'b0;
  logic           Reset     = 1'b1;
  logic           start     = 1'b0;
  logic [9:0]     ShipX, ShipY, ShipS;
  logic [NM*10-1:0] MetX, MetY, MetS;
  logic [1:0]     state, lives;
  logic           hit, invuln, game_over;
  logic [15:0]    score;

  initial forever #5 frame_clk = ~frame_clk;

  hit_tracker #(
    .NUM_METEORS   (NM),
    .LIVES_INIT    (LIVES_INIT),
    .INVULN_FRAMES (INVULN_FRAMES)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .start     (start),
    .ShipX     (ShipX),
    .ShipY     (ShipY),
    .ShipS     (ShipS),
    .MetX      (MetX),
    .MetY      (MetY),
    .MetS      (MetS),
    .state     (state),
    .lives     (lives),
    .hit       (hit),
    .invuln    (invuln),
    .game_over (game_over),
    .score     (score)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {st,lv,hit,inv,go,score}=%h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: frame-by-frame game rules, invulnerability tracked as
  // frames remaining. State numbers follow the published encoding.
  // ---------------------------------------------------------------------------
  int m_state    = 0;
  int m_lives    = 0;
  int m_score    = 0;
  int m_inv_left = 0;
  bit m_hit      = 1'b0;

  logic [W-1:0] exp_q[$];

  function automatic bit model_collision();
    for (int i = 0; i < NM; i++) begin
      int dx, dy, reach;
      dx = int'(ShipX) - int'(MetX[i*10 +: 10]);
      dy = int'(ShipY) - int'(MetY[i*10 +: 10]);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      reach = int'(ShipS) + int'(MetS[i*10 +: 10]);
      if ((MetS[i*10 +: 10] != 0) && (dx < reach) && (dy < reach)) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_state    = 0;
      m_lives    = 0;
      m_score    = 0;
      m_inv_left = 0;
      m_hit      = 1'b0;
      exp_q.delete();
    end else begin
      bit col;
      int old;
      col   = model_collision();
      old   = m_state;
      m_hit = 1'b0;
      case (old)
        0, 3: if (start) begin
          m_state = 1;
          m_lives = LIVES_INIT;
        end
        1: if (col) begin
          m_hit = 1'b1;
          if (m_lives > 1) begin
            m_lives    = m_lives - 1;
            m_state    = 2;
            m_inv_left = INVULN_FRAMES;
          end else begin
            m_lives = 0;
            m_state = 3;
          end
        end
        default: begin
          m_inv_left = m_inv_left - 1;
          if (m_inv_left == 0) m_state = 1;
        end
      endcase
      if (SCORE_ON) begin
        if ((old == 0 || old == 3) && start) m_score = 0;
        else if ((old == 1 || old == 2) && m_score < 65535) m_score = m_score + 1;
      end
      exp_q.push_back({2'(m_state), 2'(m_lives), m_hit, (m_state == 2),
                       (m_state == 3), 16'(m_score)});
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: every falling edge, outputs against reset values or the model.
  // ---------------------------------------------------------------------------
  always @(negedge frame_clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    act = {state, lives, hit, invuln, game_over, score};
    if (Reset) begin
      chk_vec("reset_outputs", act, '0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_vec("cycle", act, e);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_frame();
    @(negedge frame_clk);
  endtask

  task automatic set_met(input int i, input int x, input int y, input int s);
    MetX[i*10 +: 10] = 10'(x);
    MetY[i*10 +: 10] = 10'(y);
    MetS[i*10 +: 10] = 10'(s);
  endtask

  task automatic clear_mets();
    MetS = '0;
  endtask

  task automatic wait_invuln_end(input string name, input int exp_frames);
    int n;
    n = 0;
    while (invuln && n < 200) begin
      n++;
      next_frame();
    end
    chk(name, n, exp_frames);
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_errors++;
    summary();
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int mscore;
    ShipX = 10'd100; ShipY = 10'd100; ShipS = 10'd8;
    MetX  = '0;      MetY  = '0;      MetS  = '0;

    // Reset values
    repeat (2) next_frame();
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 0);
    chk("rst_hit", hit, 0);
    chk("rst_score", score, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_game_over", game_over, 0);
    #1 Reset = 1'b0;

    // Start a game, score counts up
    next_frame();
    start = 1'b1;
    next_frame();
    start = 1'b0;
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    next_frame(); chk("score_1", score, SCORE_ON ? 1 : 0);
    next_frame(); chk("score_2", score, SCORE_ON ? 2 : 0);
    next_frame(); chk("score_3", score, SCORE_ON ? 3 : 0);

    // Overlap 10 < 12: one hit, 60 invulnerable frames
    set_met(0, 110, 100, 4);
    next_frame();
    clear_mets();
    chk("hit1_pulse", hit, 1);
    chk("hit1_lives", lives, 2);
    chk("hit1_invuln", invuln, 1);
    chk("hit1_state", state, 2);
    wait_invuln_end("hit1_invuln_frames", 60);
    chk("hit1_back_play", state, 1);
    chk("hit1_pulse_gone", hit, 0);

    // Touching edge (12 not < 12) and empty slot: no hit
    set_met(0, 112, 100, 4);
    next_frame();
    chk("edge_no_hit", hit, 0);
    chk("edge_lives", lives, 2);
    set_met(0, 100, 100, 0);
    next_frame();
    chk("empty_slot_no_hit", hit, 0);
    chk("empty_slot_state", state, 1);

    // Three overlapping meteors: a single hit, kept present through INVULN
    set_met(0, 110, 100, 4);
    set_met(1, 100, 108, 4);
    set_met(2, 100, 100, 2);
    next_frame();
    chk("multi_hit_pulse", hit, 1);
    chk("multi_hit_lives", lives, 1);
    wait_invuln_end("multi_invuln_frames", 60);
    chk("first_play_frame", state, 1);
    next_frame();
    chk("final_hit_state", state, 3);
    chk("final_hit_pulse", hit, 1);
    chk("final_hit_lives", lives, 0);
    chk("final_game_over", game_over, 1);
    mscore = m_score;
    clear_mets();
    repeat (3) next_frame();
    chk("over_hit_low", hit, 0);
    chk("over_score_frozen", score, SCORE_ON ? mscore : 0);
    chk("over_model_frozen", m_score, mscore);

    // Restart from OVER
    start = 1'b1;
    next_frame();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);

    // Reset in the middle of INVULN
    set_met(0, 110, 100, 4);
    next_frame();
    clear_mets();
    chk("pre_reset_state", state, 2);
    repeat (5) next_frame();
    @(posedge frame_clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_lives", lives, 0);
    chk("midrst_hit", hit, 0);
    chk("midrst_invuln", invuln, 0);
    chk("midrst_game_over", game_over, 0);
    chk("midrst_score", score, 0);
    next_frame();
    #1 Reset = 1'b0;
    next_frame();
    chk("post_rst_idle", state, 0);
    start = 1'b1;
    next_frame();
    start = 1'b0;
    chk("fresh_state", state, 1);
    chk("fresh_lives", lives, 3);

    // Randomized frames
    for (int it = 0; it < 3000; it++) begin
      int sx, sy;
      next_frame();
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        ShipX = 10'($urandom_range(0, 1023));
        ShipY = 10'($urandom_range(0, 1023));
        ShipS = 10'($urandom_range(0, 1023));
        for (int i = 0; i < NM; i++) begin
          set_met(i, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
      end else begin
        sx = $urandom_range(200, 300);
        sy = $urandom_range(200, 300);
        ShipX = 10'(sx);
        ShipY = 10'(sy);
        ShipS = 10'($urandom_range(1, 10));
        for (int i = 0; i < NM; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            set_met(i, sx + $urandom_range(0, 40) - 20, sy + $urandom_range(0, 40) - 20,
                    $urandom_range(0, 8));
          end else begin
            set_met(i, $urandom_range(0, 1023), $urandom_range(600, 1023), $urandom_range(0, 3));
          end
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 Reset = 1'b1;
        next_frame();
        #1 Reset = 1'b0;
      end
    end

    repeat (2) next_frame();
    summary();
    $finish;
  end

endmodule
